// File: rtl/config_loader.sv
// config_loader: streams a bitstream into a serial fabric configuration chain.
// Words arrive over a valid/ready handshake. Each bit is presented on config_in
// for one low and one high phase of a generated config_clk. All outputs are
// registered and are computed from the next state.

module config_loader #(
    parameter int CONFIG_WIDTH = 40,
    parameter int WORD_WIDTH   = 32,
    parameter int HALF_PERIOD  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [WORD_WIDTH-1:0]             word_data,
    input  logic                              word_valid,
    output logic                              word_ready,
    output logic                              config_in,
    output logic                              config_clk,
    output logic                              config_en,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(CONFIG_WIDTH+1)-1:0] bit_count
);

    localparam int BCW = $clog2(CONFIG_WIDTH + 1);
    localparam int BIW = $clog2(WORD_WIDTH + 1);
    localparam int PCW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [BCW-1:0] CFG_LAST   = BCW'(CONFIG_WIDTH);
    localparam logic [BCW-1:0] CNT_ONE    = BCW'(1);
    localparam logic [BIW-1:0] WORD_LAST  = BIW'(WORD_WIDTH);
    localparam logic [BIW-1:0] IDX_ONE    = BIW'(1);
    localparam logic [PCW-1:0] PHASE_LAST = PCW'(HALF_PERIOD - 1);
    localparam logic [PCW-1:0] PHASE_ONE  = PCW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        SHIFT_LO  = 3'd2,
        SHIFT_HI  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [PCW-1:0]         phase_r;
    logic [PCW-1:0]         phase_s;
    logic [WORD_WIDTH-1:0]  shift_r;
    logic [WORD_WIDTH-1:0]  shift_s;
    logic [BIW-1:0]         bit_idx_r;
    logic [BIW-1:0]         bit_idx_s;
    logic [BCW-1:0]         bit_count_s;
    logic                   config_in_s;

    // A load is in progress in these states; busy and config_en follow it.
    function automatic logic in_load(input state_t s);
        logic r;
        case (s)
            WAIT_WORD, SHIFT_LO, SHIFT_HI: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state, phase counting, shifting and bit accounting.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        shift_s     = shift_r;
        bit_idx_s   = bit_idx_r;
        bit_count_s = bit_count;
        if (abort && (state_r != IDLE)) begin
            // Abort beats any handshake or phase change in the same cycle.
            state_s = IDLE;
            phase_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s     = WAIT_WORD;
                        bit_count_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid && word_ready) begin
                        shift_s   = word_data;
                        bit_idx_s = '0;
                        phase_s   = '0;
                        state_s   = SHIFT_LO;
                    end else begin
                        state_s = WAIT_WORD;
                    end
                end
                SHIFT_LO: begin
                    if (phase_r == PHASE_LAST) begin
                        phase_s = '0;
                        state_s = SHIFT_HI;
                    end else begin
                        phase_s = phase_r + PHASE_ONE;
                    end
                end
                SHIFT_HI: begin
                    if (phase_r == PHASE_LAST) begin
                        phase_s     = '0;
                        shift_s     = shift_r >> 1;
                        bit_count_s = bit_count + CNT_ONE;
                        bit_idx_s   = bit_idx_r + IDX_ONE;
                        // Completion wins, so a partial last word never asks
                        // for another word.
                        if (bit_count_s == CFG_LAST) begin
                            state_s = DONE;
                        end else if (bit_idx_s == WORD_LAST) begin
                            state_s = WAIT_WORD;
                        end else begin
                            state_s = SHIFT_LO;
                        end
                    end else begin
                        phase_s = phase_r + PHASE_ONE;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end

        // A new bit is presented on entry to the low phase; otherwise the
        // serial output holds so it is stable across the rising edge.
        if (state_s == SHIFT_LO) begin
            config_in_s = shift_s[0];
        end else begin
            config_in_s = config_in;
        end
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            phase_r    <= '0;
            shift_r    <= '0;
            bit_idx_r  <= '0;
            bit_count  <= '0;
            config_in  <= 1'b0;
            config_clk <= 1'b0;
            config_en  <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            shift_r    <= shift_s;
            bit_idx_r  <= bit_idx_s;
            bit_count  <= bit_count_s;
            config_in  <= config_in_s;
            config_clk <= (state_s == SHIFT_HI);
            config_en  <= in_load(state_s);
            word_ready <= (state_s == WAIT_WORD);
            busy       <= in_load(state_s);
            done       <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader. Expected serial bits are pushed to a
// scoreboard queue as words are offered and popped on each config_clk rise.
// A second instance with a slow shift clock checks phase timing cycle by cycle.

module tb_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        config_in;
    logic        config_clk;
    logic        config_en;
    logic        busy;
    logic        done;
    logic [5:0]  bit_count;

    logic        b_start;
    logic        b_abort;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic        b_cin;
    logic        b_cclk;
    logic        b_en;
    logic        b_busy;
    logic        b_done;
    logic [3:0]  b_bit_count;

    int   checks = 0;
    int   errors = 0;
    int   rises  = 0;
    int   dones  = 0;
    logic exp_q[$];
    logic prev_cclk = 1'b0;
    logic prev_cin  = 1'b0;

    config_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .config_in(config_in), .config_clk(config_clk), .config_en(config_en),
        .busy(busy), .done(done), .bit_count(bit_count)
    );

    config_loader #(.CONFIG_WIDTH(8), .WORD_WIDTH(32), .HALF_PERIOD(3)) dut_hp (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .word_data(b_data), .word_valid(b_valid), .word_ready(b_ready),
        .config_in(b_cin), .config_clk(b_cclk), .config_en(b_en),
        .busy(b_busy), .done(b_done), .bit_count(b_bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(w[i]);
        end
    endtask

    // Scoreboard side: on every config_clk rise compare config_in with the
    // next expected bit and with the value held during the low phase.
    always @(negedge clk) begin
        if (config_clk && !prev_cclk) begin
            rises <= rises + 1;
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                chk("sb_bit", 64'(config_in), 64'(exp_q.pop_front()));
            end
            chk("bit_stable", 64'(config_in), 64'(prev_cin));
        end
        if (done) begin
            dones <= dones + 1;
        end
        prev_cclk <= config_clk;
        prev_cin  <= config_in;
    end

    // One complete 40-bit load of two words; optional stall at the word
    // boundary and an optional stray start pulse while busy.
    task automatic run_load(input logic [31:0] w0, input logic [31:0] w1,
                            input bit stall, input bit poke_start);
        int base_r;
        int base_d;
        int widx;
        int t;
        base_r = rises;
        base_d = dones;
        widx   = 0;
        word_data  = w0;
        word_valid = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_wait_word", 64'({busy, word_ready, config_en, config_clk, bit_count}),
            64'({1'b1, 1'b1, 1'b1, 1'b0, 6'd0}));
        t = 0;
        while (!done && t < 400) begin
            if (stall && word_ready && !word_valid) begin
                for (int k = 0; k < 10; k++) begin
                    chk("stall_hold", 64'({config_clk, config_en, bit_count}),
                        64'({1'b0, 1'b1, 6'd32}));
                    @(negedge clk);
                end
                word_valid = 1'b1;
                stall      = 1'b0;
            end
            if (word_ready && word_valid) begin
                @(posedge clk);
                #1;
                widx++;
                if (widx == 1) begin
                    word_data  = w1;
                    word_valid = !stall;
                end else begin
                    word_data  = 32'd0;
                    word_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (poke_start && bit_count == 6'd10) begin
                start = 1'b1;
                @(negedge clk);
                start      = 1'b0;
                poke_start = 1'b0;
            end
            t++;
        end
        chk("done_seen", 64'(done), 64'(1));
        chk("done_idle_flags", 64'({busy, config_en, config_clk, word_ready}), 64'(0));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("bit_count_hold", 64'(bit_count), 64'(40));
        chk("rise_count", 64'(rises - base_r), 64'(40));
        chk("done_count", 64'(dones - base_d), 64'(1));
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        chk("words_taken", 64'(widx), 64'(2));
    endtask

    initial begin
        int   t;
        int   n;
        int   base_r;
        int   base_d;
        logic lp;
        logic eb;

        rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = 32'd0;
        b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({config_in, config_clk, config_en, word_ready, busy, done, bit_count}), 64'(0));
        chk("reset_state_hp", 64'({b_cin, b_cclk, b_en, b_ready, b_busy, b_done, b_bit_count}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_idle", 64'({busy, config_en, word_ready, done}), 64'(0));

        // basic load with a stray start pulse mid-load
        push_bits(32'hA5A5_A5A5, 32);
        push_bits(32'h0000_00FF, 8);
        run_load(32'hA5A5_A5A5, 32'h0000_00FF, 1'b0, 1'b1);

        // stall at the word boundary; upper bits of the last word discarded
        push_bits(32'h3C96_0F71, 32);
        push_bits(32'hDEAD_BE3C, 8);
        run_load(32'h3C96_0F71, 32'hDEAD_BE3C, 1'b1, 1'b0);

        // abort after 17 rises
        base_r = rises;
        base_d = dones;
        push_bits(32'hC3C3_C3C3, 32);
        word_data = 32'hC3C3_C3C3; word_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; lp = config_clk; t = 0;
        while (n < 17 && t < 300) begin
            if (word_ready && word_valid) begin
                @(posedge clk);
                #1;
                word_valid = 1'b0;
            end
            @(negedge clk);
            if (config_clk && !lp) n++;
            lp = config_clk;
            t++;
        end
        chk("abort_reached_17", 64'(n), 64'(17));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_outputs", 64'({config_en, busy, config_clk, word_ready, done}), 64'(0));
        repeat (3) @(negedge clk);
        chk("abort_rise_total", 64'(rises - base_r), 64'(17));
        chk("abort_no_done", 64'(dones - base_d), 64'(0));
        chk("abort_sb_left", 64'(exp_q.size()), 64'(15));
        exp_q.delete();

        // fresh load after abort restarts from bit 0
        push_bits(32'h1234_5678, 32);
        push_bits(32'h0000_009A, 8);
        run_load(32'h1234_5678, 32'h0000_009A, 1'b0, 1'b0);

        // asynchronous reset while config_clk is high
        push_bits(32'h8765_4321, 32);
        word_data = 32'h8765_4321; word_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!config_clk && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_clk_high", 64'(config_clk), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({config_in, config_clk, config_en, word_ready, busy, done, bit_count}), 64'(0));
        word_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("no_restart_after_reset", 64'({busy, word_ready, config_en, bit_count}), 64'(0));

        // reload after reset rewrites the chain from bit 0
        push_bits(32'h0F0F_1234, 32);
        push_bits(32'h0000_0055, 8);
        run_load(32'h0F0F_1234, 32'h0000_0055, 1'b0, 1'b0);

        // slow shift clock instance: 3-cycle phases, 8 bits of 0x5A
        b_data = 32'h0000_005A; b_valid = 1'b1; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("hp_ready", 64'({b_ready, b_busy, b_en, b_cclk}), 64'({1'b1, 1'b1, 1'b1, 1'b0}));
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            eb = b_data[i / 6];
            chk("hp_wave", 64'({b_cclk, b_cin, b_en, b_done}),
                64'({(((i / 3) % 2) == 1), eb, 1'b1, 1'b0}));
        end
        @(negedge clk);
        chk("hp_done", 64'({b_done, b_busy, b_en, b_cclk, b_bit_count}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 4'd8}));
        @(negedge clk);
        chk("hp_done_pulse", 64'({b_done, b_bit_count}), 64'({1'b0, 4'd8}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 40, total fabric configuration bits to shift.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, width of bitstream words from the source.
REQ-003 SHALL have parameter HALF_PERIOD, default 1 (legal >=1), clk cycles per config_clk phase.
REQ-004 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-007 SHALL have port abort  input  1  cancel the load in progress.
REQ-008 SHALL have port word_data  input  WORD_WIDTH  bitstream word, LSB shifted first.
REQ-009 SHALL have port word_valid  input  1  word_data is valid.
REQ-010 SHALL have port word_ready  output  1  loader accepts a word this cycle.
REQ-011 SHALL have port config_in  output  1  serial bit to the fabric chain.
REQ-012 SHALL have port config_clk  output  1  generated shift clock to the fabric.
REQ-013 SHALL have port config_en  output  1  fabric shift enable.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse on load completion.
REQ-016 SHALL have port bit_count  output  $clog2(CONFIG_WIDTH+1)  bits shifted so far.

Function
REQ-017 SHALL use states IDLE, WAIT_WORD, SHIFT_LO, SHIFT_HI, DONE; all outputs registered.
REQ-018 IDLE: start=1 -> WAIT_WORD next cycle, bit_count cleared to 0; start ignored in every other state.
REQ-019 WAIT_WORD: word_ready=1, config_en=1, config_clk=0; a handshake (word_valid & word_ready) loads the shift register, resets the per-word bit index and moves to SHIFT_LO.
REQ-020 SHIFT_LO: config_clk=0, config_in=shift_reg[0], held HALF_PERIOD cycles, then SHIFT_HI.
REQ-021 SHIFT_HI: config_clk=1 and config_in unchanged for HALF_PERIOD cycles; on exit, shift right by 1 and increment bit_count.
REQ-022 SHIFT_HI exit: bit_count reaching CONFIG_WIDTH -> DONE; else word exhausted (WORD_WIDTH bits used) -> WAIT_WORD; else SHIFT_LO.
REQ-023 Exactly CONFIG_WIDTH rising config_clk edges per completed load, config_in stable across each edge.
REQ-024 Final partial word: only the remaining CONFIG_WIDTH mod WORD_WIDTH LSBs are shifted; upper bits discarded, no further word requested.
REQ-025 DONE: config_en=0, config_clk=0, done=1 for exactly one cycle, busy=0, then IDLE; bit_count holds CONFIG_WIDTH until the next start.
REQ-026 busy=1 in WAIT_WORD, SHIFT_LO, SHIFT_HI; 0 in IDLE and DONE.
REQ-027 word_ready=1 only in WAIT_WORD; word_valid low in WAIT_WORD stalls with config_clk low, no edges, no timeout.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, config_en=0, config_clk=0, no done pulse; abort has priority over handshake and phase transitions in the same cycle.
REQ-029 Throughput: 2*HALF_PERIOD clk cycles per bit; one bubble cycle (WAIT_WORD) per word boundary when word_valid is already high.

Reset
REQ-030 rst=1 SHALL force immediately: state IDLE, config_in=0, config_clk=0, config_en=0, word_ready=0, busy=0, done=0, bit_count=0, shift register 0.
REQ-031 Reset mid-load SHALL abandon the load without done; a fresh start is needed, and the fabric chain is rewritten from bit 0.

Verification
REQ-032 Defaults, start, word_valid held high with 0xA5A5A5A5 then 0x000000FF -> 40 config_clk rises, sampled bits = LSB-first 32 bits of word 0 then 8 bits 0xFF; one done pulse; bit_count=40.
REQ-033 HALF_PERIOD=3, CONFIG_WIDTH=8, word 0x5A -> each config_clk phase lasts 3 clk cycles; first rise 3 cycles after SHIFT_LO entry; done 48+ cycles after handshake.
REQ-034 word_valid dropped for 10 cycles at the word boundary -> config_clk low, config_en high, bit_count=32 throughout stall; resumes correctly.
REQ-035 abort asserted after 17 config_clk rises -> next cycle config_en=0, busy=0, no done; new start reloads from bit_count=0.
REQ-036 rst asserted asynchronously between clk edges during SHIFT_HI -> config_clk drops to 0 without waiting for clk; all outputs at reset values.
REQ-037 start pulsed while busy and abort in IDLE -> both ignored; load completes unaltered, bit stream matches REQ-032.
